// File: rtl/efuse_ctrl.sv
// rtl/efuse_ctrl.sv - eFuse macro sequencer: serial read, per-bit program pulses, optional verify read-back
module efuse_ctrl #(
  parameter int DATA_W = 32,
  parameter int DIV    = 10,
  parameter int PGM_W  = 4,
  parameter int SETUP  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              read_start,
  input  logic              prog_start,
  input  logic              verify_en,
  input  logic [DATA_W-1:0] din,
  output logic              read_ack,
  output logic              prog_ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              verify_err,
  output logic              EFUSE_SCLK,
  output logic              EFUSE_CS,
  output logic              EFUSE_RW,
  output logic              EFUSE_PGM,
  input  logic              EFUSE_DOUT
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(2 * SETUP) + 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW:0]   PGM_LIM   = (DW + 1)'(PGM_W);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * SETUP - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_t;

  state_t            state, state_n;
  logic [DW-1:0]     div_cnt;
  logic [HW-1:0]     half_cnt;
  logic [IW-1:0]     bit_idx;
  logic              phase_lo;
  logic              mode_prog, ven_q, vfy_q;
  logic [DATA_W-1:0] din_q, shreg;
  logic              tick, accept, finish_read;

  assign tick        = (div_cnt == DIV_LAST);
  assign finish_read = (state == S_HOLD) && (state_n == S_DONE) && !mode_prog;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      S_IDLE: if (prog_start || read_start) begin
        state_n = S_SETUP;
        accept  = 1'b1;
      end
      S_SETUP: if (tick && half_cnt == HALF_LAST) state_n = S_SHIFT;
      S_SHIFT: if (tick && phase_lo && bit_idx == BIT_LAST) state_n = S_HOLD;
      S_HOLD:  if (tick && half_cnt == HALF_LAST) state_n = S_DONE;
      S_DONE:  state_n = (mode_prog && ven_q) ? S_SETUP : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      half_cnt   <= '0;
      bit_idx    <= '0;
      phase_lo   <= 1'b0;
      mode_prog  <= 1'b0;
      ven_q      <= 1'b0;
      vfy_q      <= 1'b0;
      din_q      <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      verify_err <= 1'b0;
      read_ack   <= 1'b0;
      prog_ack   <= 1'b0;
    end else begin
      state      <= state_n;
      read_ack   <= accept && !prog_start;
      prog_ack   <= accept && prog_start;
      dout_valid <= finish_read;
      // Every state entry restarts the bit clock from the start of a half-period
      if (state_n != state || state == S_IDLE) begin
        div_cnt  <= '0;
        half_cnt <= '0;
        bit_idx  <= '0;
        phase_lo <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          half_cnt <= half_cnt + 1'b1;
          phase_lo <= ~phase_lo;
          if (phase_lo) bit_idx <= bit_idx + 1'b1;
        end
      end
      if (accept) begin
        mode_prog  <= prog_start;
        ven_q      <= prog_start && verify_en;
        vfy_q      <= 1'b0;
        verify_err <= 1'b0;
        if (prog_start) din_q <= din;
      end
      if (state == S_DONE && mode_prog && ven_q) begin
        mode_prog <= 1'b0;
        ven_q     <= 1'b0;
        vfy_q     <= 1'b1;
      end
      if (state == S_SHIFT && !mode_prog && !phase_lo && tick) shreg[bit_idx] <= EFUSE_DOUT;
      if (finish_read) begin
        dout <= shreg;
        if (vfy_q) verify_err <= (shreg != din_q);
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign EFUSE_CS   = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
  assign EFUSE_RW   = EFUSE_CS && mode_prog;
  assign EFUSE_SCLK = (state == S_SHIFT) && !phase_lo;
  assign EFUSE_PGM  = (state == S_SHIFT) && mode_prog && !phase_lo && din_q[bit_idx] &&
                      ({1'b0, div_cnt} < PGM_LIM);

endmodule

// File: tb/tb_efuse_ctrl.sv
// tb/tb_efuse_ctrl.sv - timeline-model bench for efuse_ctrl with a behavioural fuse array
`timescale 1ns/1ps
module tb_efuse_ctrl;
  localparam int DATA_W = 32, DIV = 10, PGM_W = 4, SETUP = 2;
  localparam int LS  = 2 * SETUP * DIV;
  localparam int LSH = 2 * DATA_W * DIV;
  localparam int TT  = 2 * LS + LSH;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        read_start = 1'b0, prog_start = 1'b0, verify_en = 1'b0;
  logic [31:0] din = '0, dout;
  logic        read_ack, prog_ack, dout_valid, busy, verify_err;
  logic        efuse_sclk, efuse_cs, efuse_rw, efuse_pgm, efuse_dout = 1'b0;

  logic        s_rs = 1'b0, s_rack, s_pack, s_dv, s_busy, s_verr;
  logic        s_sclk, s_cs, s_rw, s_pgm, s_fdout = 1'b0;
  logic [7:0]  s_dout;

  efuse_ctrl #(.DATA_W(DATA_W), .DIV(DIV), .PGM_W(PGM_W), .SETUP(SETUP)) dut (
    .clk(clk), .rstn(rstn), .read_start(read_start), .prog_start(prog_start),
    .verify_en(verify_en), .din(din), .read_ack(read_ack), .prog_ack(prog_ack),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .verify_err(verify_err),
    .EFUSE_SCLK(efuse_sclk), .EFUSE_CS(efuse_cs), .EFUSE_RW(efuse_rw),
    .EFUSE_PGM(efuse_pgm), .EFUSE_DOUT(efuse_dout));

  efuse_ctrl #(.DATA_W(8), .DIV(2), .PGM_W(1), .SETUP(1)) dut_s (
    .clk(clk), .rstn(rstn), .read_start(s_rs), .prog_start(1'b0),
    .verify_en(1'b0), .din(8'h00), .read_ack(s_rack), .prog_ack(s_pack),
    .dout(s_dout), .dout_valid(s_dv), .busy(s_busy), .verify_err(s_verr),
    .EFUSE_SCLK(s_sclk), .EFUSE_CS(s_cs), .EFUSE_RW(s_rw),
    .EFUSE_PGM(s_pgm), .EFUSE_DOUT(s_fdout));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Behavioural fuse array on the main macro port
  logic [31:0] phys = '0, stuck = '0;
  int          sc_cnt = 0;
  logic        sc_prev = 1'b0;
  logic [4:0]  sc_idx;
  always @(negedge clk) begin
    if (!efuse_cs) sc_cnt = 0;
    else if (efuse_sclk && !sc_prev) sc_cnt++;
    sc_prev = efuse_sclk;
    sc_idx  = 5'(sc_cnt - 1);
    if (efuse_pgm && sc_cnt > 0 && !stuck[sc_idx]) phys[sc_idx] = 1'b1;
    efuse_dout = (sc_cnt > 0) ? phys[sc_idx] : 1'b0;
  end

  logic [7:0] s_pat = 8'h3C;
  int         s_cnt = 0, s_sclk_n = 0;
  logic       s_prev = 1'b0;
  always @(negedge clk) begin
    if (!s_cs) s_cnt = 0;
    else if (s_sclk && !s_prev) begin s_cnt++; s_sclk_n++; end
    s_prev  = s_sclk;
    s_fdout = (s_cnt > 0) ? s_pat[3'(s_cnt - 1)] : 1'b0;
  end

  // Reference: an operation is a fixed timeline of TT+1 cycles measured from its accepting edge
  bit          m_act, m_prog, m_ven, m_vfy, m_ack_r, m_ack_p;
  int          m_t = 0, mb;
  logic [31:0] m_din = '0, m_fuse = '0, m_dout = '0;
  logic        m_verr = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (!rstn) begin
      m_act = 0; m_ack_r = 0; m_ack_p = 0; m_dout = '0; m_verr = 1'b0;
    end else begin
      m_ack_r = 0; m_ack_p = 0;
      if (m_act) begin
        if (m_t == TT) begin
          if (m_prog && m_ven) begin m_prog = 0; m_vfy = 1; m_t = 0; end
          else m_act = 0;
        end else m_t++;
      end else if (prog_start || read_start) begin
        m_act = 1; m_t = 0; m_prog = prog_start; m_ven = prog_start && verify_en;
        m_vfy = 0; m_verr = 1'b0;
        if (prog_start) begin m_din = din; m_ack_p = 1; end else m_ack_r = 1;
      end
      if (m_act && m_prog && m_t >= LS && m_t < LS + LSH && (m_t - LS) % (2 * DIV) == 0) begin
        mb = (m_t - LS) / (2 * DIV);
        if (m_din[5'(mb)] && !stuck[5'(mb)]) m_fuse[5'(mb)] = 1'b1;
      end
      if (m_act && !m_prog && m_t == TT) begin
        m_dout = m_fuse;
        if (m_vfy) m_verr = (m_fuse != m_din);
      end
    end
  end

  int   c_sclk, c_pgm_pulse, c_pgm_hi, c_rw_hi, c_dv, c_rack, c_pack, dv_cyc, rack_cyc, pack_cyc;
  logic p_sclk = 1'b0, p_pgm = 1'b0;
  bit   in_sh;
  int   w;
  logic [4:0] bi;
  logic [8:0] e;
  always @(negedge clk) if (cyc >= 1) begin
    in_sh = m_act && m_t >= LS && m_t < LS + LSH;
    w  = in_sh ? (m_t - LS) % (2 * DIV) : 0;
    bi = in_sh ? 5'((m_t - LS) / (2 * DIV)) : 5'd0;
    e  = {m_act, m_act && m_t < TT, m_act && m_t < TT && m_prog, in_sh && w < DIV,
          in_sh && m_prog && w < PGM_W && m_din[bi], m_ack_r, m_ack_p,
          m_act && !m_prog && m_t == TT, m_verr};
    chk("ctl{busy,cs,rw,sclk,pgm,rack,pack,dv,verr}",
        {busy, efuse_cs, efuse_rw, efuse_sclk, efuse_pgm, read_ack, prog_ack, dout_valid, verify_err}, e);
    chk("dout", dout, m_dout);
    if (efuse_sclk && !p_sclk) c_sclk++;
    if (efuse_pgm && !p_pgm) c_pgm_pulse++;
    if (efuse_pgm) c_pgm_hi++;
    if (efuse_rw) c_rw_hi++;
    if (dout_valid) begin c_dv++; dv_cyc = cyc; end
    if (read_ack) begin c_rack++; rack_cyc = cyc; end
    if (prog_ack) begin c_pack++; pack_cyc = cyc; end
    p_sclk = efuse_sclk; p_pgm = efuse_pgm;
  end

  task automatic clr();
    c_sclk = 0; c_pgm_pulse = 0; c_pgm_hi = 0; c_rw_hi = 0; c_dv = 0; c_rack = 0; c_pack = 0;
    dv_cyc = 0; rack_cyc = 0; pack_cyc = 0;
  endtask

  task automatic preload(input logic [31:0] v);
    phys = v; m_fuse = v;
  endtask

  task automatic start_op(input bit p, input bit r, input bit ven, input logic [31:0] d);
    @(negedge clk);
    prog_start = p; read_start = r; verify_en = ven; din = d;
    @(posedge clk); #1 acc_cyc = cyc;
    @(negedge clk);
    prog_start = 1'b0; read_start = 1'b0; verify_en = 1'(($urandom)); din = $urandom;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 4000 && (m_act || busy); k++) @(negedge clk);
    n_cmp++;
    if (m_act || busy) begin
      n_bad++;
      $display("FAIL idle_timeout: busy=%0b model_active=%0b, required both 0", busy, m_act);
    end
  endtask

  initial begin
    clr();
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_dout", dout, 0);
    rstn = 1'b1;

    preload(32'hA5A5_0F0F); clr();
    start_op(0, 1, 0, 0); wait_idle();
    chk("read_ack_latency", rack_cyc - acc_cyc + 1, 1);
    chk("read_valid_latency", dv_cyc - acc_cyc + 1, 721);
    chk("read_sclk_pulses", c_sclk, 32);
    chk("read_dout", dout, 32'hA5A5_0F0F);

    preload(0); clr();
    start_op(1, 0, 0, 32'h8000_0001); wait_idle();
    chk("prog_ack_latency", pack_cyc - acc_cyc + 1, 1);
    chk("prog_pgm_pulses", c_pgm_pulse, 2);
    chk("prog_pgm_cycles", c_pgm_hi, 8);
    chk("prog_rw_cycles", c_rw_hi, 720);
    chk("prog_no_valid", c_dv, 0);
    chk("prog_dout_held", dout, 32'hA5A5_0F0F);

    preload(0); stuck = 32'h8; clr();
    start_op(1, 0, 1, 32'h0000_00FF); wait_idle();
    chk("verify_valid_count", c_dv, 1);
    chk("verify_valid_latency", dv_cyc - acc_cyc + 1, 1442);
    chk("verify_dout", dout, 32'h0000_00F7);
    chk("verify_err", verify_err, 1);
    chk("verify_read_ack", c_rack, 0);
    stuck = '0;

    clr();
    start_op(1, 1, 0, $urandom);
    repeat (50) @(negedge clk);
    read_start = 1'b1; @(negedge clk); read_start = 1'b0;
    wait_idle();
    chk("both_prog_ack", c_pack, 1);
    chk("both_no_read_ack", c_rack, 0);
    chk("busy_start_no_valid", c_dv, 0);

    preload(0); clr();
    start_op(1, 0, 0, 32'h1);
    for (int k = 0; k < 200 && !efuse_pgm; k++) @(negedge clk);
    chk("mid_pgm_seen", efuse_pgm, 1);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs",
        {busy, efuse_cs, efuse_rw, efuse_sclk, efuse_pgm, read_ack, prog_ack, dout_valid, verify_err}, 0);
    chk("mid_reset_dout", dout, 0);
    rstn = 1'b1;
    start_op(0, 1, 0, 0); wait_idle();
    chk("after_reset_read", dout, 32'h1);

    @(negedge clk); s_rs = 1'b1;
    @(posedge clk); #1 acc_cyc = cyc;
    @(negedge clk); s_rs = 1'b0; s_sclk_n = 0;
    chk("small_read_ack", s_rack, 1);
    for (int k = 0; k < 200 && !s_dv; k++) @(negedge clk);
    chk("small_valid_latency", cyc - acc_cyc + 1, 41);
    chk("small_dout", s_dout, 8'h3C);
    chk("small_sclk_pulses", s_sclk_n, 8);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(3) == 0) begin
        preload($urandom);
        stuck = ($urandom_range(1) == 1) ? (32'h1 << $urandom_range(31)) : 32'h0;
      end
      case ($urandom_range(2))
        0:       start_op(0, 1, 0, $urandom);
        1:       start_op(1, 0, 1'($urandom_range(1)), $urandom);
        default: start_op(1, 1, 1'($urandom_range(1)), $urandom);
      endcase
      if ($urandom_range(2) == 0) begin
        repeat ($urandom_range(600, 1)) @(negedge clk);
        read_start = 1'($urandom); prog_start = 1'($urandom);
        @(negedge clk);
        read_start = 1'b0; prog_start = 1'b0;
      end
      if ($urandom_range(5) == 0) begin
        repeat ($urandom_range(700, 1)) @(negedge clk);
        rstn = 1'b0; repeat (2) @(negedge clk); rstn = 1'b1;
      end
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
